// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared definitions for the load/store unit. It holds the
//               store/load type encodings, the access-size and FSM state
//               enums, and helpers that decode the access size and detect
//               misalignment.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

  // Store type encodings (funct3 style)
  localparam logic [2:0] ST_B  = 3'b000;
  localparam logic [2:0] ST_H  = 3'b001;
  localparam logic [2:0] ST_W  = 3'b010;

  // Load type encodings (funct3 style)
  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } lsu_state_t;

  // Any encoding that is not recognised falls back to a word access.
  function automatic lsu_size_t lsu_size(input logic       we,
                                         input logic [2:0] st,
                                         input logic [2:0] lt);
    lsu_size_t sz;
    sz = SZ_WORD;
    if (we) begin
      case (st)
        ST_B:    sz = SZ_BYTE;
        ST_H:    sz = SZ_HALF;
        ST_W:    sz = SZ_WORD;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (lt)
        LD_B, LD_BU: sz = SZ_BYTE;
        LD_H, LD_HU: sz = SZ_HALF;
        LD_W:        sz = SZ_WORD;
        default:     sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic lsu_misaligned(input lsu_size_t  sz,
                                          input logic [1:0] off);
    logic mis;
    case (sz)
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane steering for the load/store unit.
//               Store side: byte enables and lane-replicated write data.
//               Load side : byte/half extraction with sign/zero extension.
// Ports       : we_i, store_type_i, load_type_i - access kind
//               offset_i                         - byte offset addr[1:0]
//               wdata_i / wdata_o                - raw / replicated store data
//               rword_i / rdata_o                - bus read word / load result
//               be_o                             - byte enables
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  store_type_i,
  input  logic [2:0]  load_type_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  lsu_size_t   size;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_ext;

  always_comb begin
    size     = lsu_size(we_i, store_type_i, load_type_i);
    byte_sel = rword_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? rword_i[31:16] : rword_i[15:0];
    sign_ext = (load_type_i == LD_B) || (load_type_i == LD_H);

    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rword_i;
    case (size)
      SZ_BYTE: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << {offset_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sign_ext & half_sel[15]}}, half_sel};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit between the CPU datapath
//               and a req/gnt + rvalid data bus. Misaligned accesses complete
//               with misalign_err and no bus activity; bus accesses that see
//               no gnt/rvalid within TIMEOUT_CYCLES complete with bus_err.
// Ports       : clk_i, rst_ni (async, active low)
//               CPU side : mem_req_i, d_wr_en_i, store_type_i, load_type_i,
//                          addr_i, wdata_i -> stall_o, rdata_o, done_o,
//                          misalign_err_o, bus_err_o
//               Bus side : bus_req_o, bus_we_o, bus_addr_o, bus_be_o,
//                          bus_wdata_o <- bus_gnt_i, bus_rvalid_i, bus_rdata_i
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_req_i,
  input  logic        d_wr_en_i,
  input  logic [2:0]  store_type_i,
  input  logic [2:0]  load_type_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        misalign_err_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       st_q, st_d;
  logic [2:0]       lt_q, lt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             misalign_q, misalign_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       al_be;
  logic [31:0]      al_wdata;
  logic [31:0]      al_rdata;
  logic             misaligned_now;
  logic             in_req;

  // Steering always works on the captured access so the bus sees stable
  // values for the whole request even if the CPU inputs change.
  lsu_align u_align (
    .we_i         (we_q),
    .store_type_i (st_q),
    .load_type_i  (lt_q),
    .offset_i     (addr_q[1:0]),
    .wdata_i      (wdata_q),
    .rword_i      (bus_rdata_i),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .rdata_o      (al_rdata)
  );

  assign misaligned_now = lsu_misaligned(lsu_size(d_wr_en_i, store_type_i, load_type_i),
                                         addr_i[1:0]);

  // Bus outputs are qualified by the REQ state so reset (which forces IDLE)
  // clears them immediately and a timeout drops the request.
  assign in_req         = (state_q == REQ);
  assign bus_req_o      = in_req;
  assign bus_we_o       = in_req & we_q;
  assign bus_addr_o     = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus_be_o       = in_req ? al_be : 4'd0;
  assign bus_wdata_o    = (in_req & we_q) ? al_wdata : 32'd0;

  assign done_o         = (state_q == DONE);
  assign stall_o        = mem_req_i & (state_q != DONE);
  assign rdata_o        = rdata_q;
  assign misalign_err_o = misalign_q;
  assign bus_err_o      = bus_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      st_q       <= 3'd0;
      lt_q       <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      st_q       <= st_d;
      lt_q       <= lt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    st_d       = st_q;
    lt_d       = lt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    bus_err_d  = bus_err_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          we_d       = d_wr_en_i;
          st_d       = store_type_i;
          lt_d       = load_type_i;
          addr_d     = addr_i;
          wdata_d    = wdata_i;
          rdata_d    = 32'd0;
          bus_err_d  = 1'b0;
          misalign_d = misaligned_now;
          cnt_d      = '0;
          state_d    = misaligned_now ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus_gnt_i) begin
          cnt_d = '0;
          if (we_q) begin
            state_d = DONE;
          end else if (bus_rvalid_i) begin
            // Zero-wait read: data arrives with the grant.
            rdata_d = al_rdata;
            state_d = DONE;
          end else begin
            state_d = WAIT_R;
          end
        end else if (cnt_q == CNT_LAST) begin
          bus_err_d = 1'b1;
          rdata_d   = 32'd0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_R: begin
        if (bus_rvalid_i) begin
          rdata_d = al_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_d = 1'b1;
          rdata_d   = 32'd0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. A behavioural model
//               computes lanes, extension, errors and completion latency
//               from access size arithmetic; a scripted bus responder
//               supplies gnt/rvalid with chosen delays.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_req = 1'b0;
  logic        d_wr_en = 1'b0;
  logic [2:0]  store_type = 3'd0;
  logic [2:0]  load_type = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        stall;
  logic [31:0] rdata;
  logic        done;
  logic        misalign_err;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .mem_req_i      (mem_req),
    .d_wr_en_i      (d_wr_en),
    .store_type_i   (store_type),
    .load_type_i    (load_type),
    .addr_i         (addr),
    .wdata_i        (wdata),
    .stall_o        (stall),
    .rdata_o        (rdata),
    .done_o         (done),
    .misalign_err_o (misalign_err),
    .bus_err_o      (bus_err),
    .bus_req_o      (bus_req),
    .bus_we_o       (bus_we),
    .bus_addr_o     (bus_addr),
    .bus_be_o       (bus_be),
    .bus_wdata_o    (bus_wdata),
    .bus_gnt_i      (bus_gnt),
    .bus_rvalid_i   (bus_rvalid),
    .bus_rdata_i    (bus_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Access width in bytes; unrecognised encodings count as words.
  function automatic int acc_bytes(input bit we, input logic [2:0] ty);
    if (we) return (ty == 3'd0) ? 1 : (ty == 3'd1) ? 2 : 4;
    if (ty == 3'd0 || ty == 3'd4) return 1;
    if (ty == 3'd1 || ty == 3'd5) return 2;
    return 4;
  endfunction

  // One access: gdly = REQ cycles before gnt (<0 never), rdly = cycles after
  // gnt before rvalid (0 = with gnt, <0 never), rw = word returned.
  task automatic do_access(input string tag, input bit we, input logic [2:0] ty,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int gdly, input int rdly, input logic [31:0] rw);
    int          nb, off, cyc, gcnt, rcnt, exp_cyc;
    bit          mis, tmo, sgn, seen, got_done;
    logic [31:0] exp_be, exp_wd, exp_rd, v;

    nb  = acc_bytes(we, ty);
    off = int'(a % 4);
    mis = (off % nb) != 0;
    sgn = !we && (ty == 3'd0 || ty == 3'd1);
    exp_be = ((32'd1 << nb) - 32'd1) << off;
    exp_wd = (nb == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
             (nb == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    v = rw >> (8 * off);
    if (nb == 1) begin
      v = v & 32'hFF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (nb == 2) begin
      v = v & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    tmo = 1'b0;
    if (mis)                            exp_cyc = 1;
    else if (gdly < 0 || gdly >= TMO) begin tmo = 1'b1; exp_cyc = 1 + TMO; end
    else if (we || rdly == 0)           exp_cyc = gdly + 2;
    else if (rdly < 0 || rdly > TMO) begin tmo = 1'b1; exp_cyc = gdly + 2 + TMO; end
    else                                exp_cyc = gdly + 2 + rdly;
    exp_rd = tmo ? 32'd0 : v;

    @(negedge clk);
    mem_req    = 1'b1;
    d_wr_en    = we;
    store_type = we ? ty : 3'($urandom);
    load_type  = we ? 3'($urandom) : ty;
    addr       = a;
    wdata      = wd;
    #1 check_eq({tag, " stall idle"}, 32'(stall), 32'd1);

    cyc = 0; gcnt = 0; rcnt = 0; seen = 1'b0; got_done = 1'b0;
    for (int k = 0; k < 60 && !got_done; k++) begin
      @(negedge clk);
      cyc++;
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = $urandom;
      if (done) begin
        got_done = 1'b1;
      end else if (bus_req) begin
        if (!seen) begin
          seen = 1'b1;
          check_eq({tag, " bus_addr"}, bus_addr, a & 32'hFFFF_FFFC);
          check_eq({tag, " bus_we"}, 32'(bus_we), 32'(we));
          check_eq({tag, " stall req"}, 32'(stall), 32'd1);
          if (we) begin
            check_eq({tag, " bus_be"}, 32'(bus_be), exp_be);
            check_eq({tag, " bus_wdata"}, bus_wdata, exp_wd);
          end
        end
        if (gcnt == gdly) begin
          bus_gnt = 1'b1;
          if (!we && rdly == 0) begin
            bus_rvalid = 1'b1;
            bus_rdata  = rw;
          end
        end
        gcnt++;
      end else if (seen) begin
        rcnt++;
        if (rcnt == rdly) begin
          bus_rvalid = 1'b1;
          bus_rdata  = rw;
        end
      end
    end

    check_eq({tag, " done"}, 32'(got_done), 32'd1);
    check_eq({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
    check_eq({tag, " bus used"}, 32'(seen), 32'(!mis));
    check_eq({tag, " stall done"}, 32'(stall), 32'd0);
    check_eq({tag, " misalign"}, 32'(misalign_err), 32'(mis));
    check_eq({tag, " bus_err"}, 32'(bus_err), 32'(tmo));
    if (!we && !mis) check_eq({tag, " rdata"}, rdata, exp_rd);
    last_rdata = rdata;

    mem_req    = 1'b0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    @(negedge clk);
    check_eq({tag, " done pulse"}, 32'(done), 32'd0);
  endtask

  int dcnt;

  initial begin
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst bus_req", 32'(bus_req), 32'd0);
    check_eq("rst bus_we", 32'(bus_we), 32'd0);
    check_eq("rst bus_be", 32'(bus_be), 32'd0);
    check_eq("rst bus_addr", bus_addr, 32'd0);
    check_eq("rst bus_wdata", bus_wdata, 32'd0);
    check_eq("rst rdata", rdata, 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    check_eq("rst errs", {30'd0, misalign_err, bus_err}, 32'd0);
    rst_n = 1'b1;

    // Directed cases
    do_access("SB", 1'b1, 3'd0, 32'h1003, 32'hA5, 0, 0, 32'd0);
    do_access("LB", 1'b0, 3'd0, 32'h2001, 32'd0, 0, 3, 32'h0000_8000);
    check_eq("LB literal", last_rdata, 32'hFFFF_FF80);
    do_access("LBU", 1'b0, 3'd4, 32'h2001, 32'd0, 0, 3, 32'h0000_8000);
    check_eq("LBU literal", last_rdata, 32'h0000_0080);
    do_access("LH mis", 1'b0, 3'd1, 32'h3001, 32'd0, 0, 0, 32'd0);
    do_access("LW tmo", 1'b0, 3'd2, 32'h3000, 32'd0, -1, 0, 32'd0);
    do_access("SW gnt15", 1'b1, 3'd2, 32'h3004, 32'h1234_5678, 15, 0, 32'd0);
    do_access("LW rv16", 1'b0, 3'd2, 32'h3008, 32'd0, 1, 16, 32'hCAFE_F00D);
    do_access("LW rv tmo", 1'b0, 3'd2, 32'h300C, 32'd0, 0, 17, 32'hCAFE_F00D);
    do_access("SW b2b", 1'b1, 3'd2, 32'h4000, 32'hDEAD_BEEF, 0, 0, 32'd0);
    do_access("LHU b2b", 1'b0, 3'd5, 32'h4002, 32'd0, 0, 1, 32'hBEEF_1234);
    check_eq("LHU literal", last_rdata, 32'h0000_BEEF);
    do_access("SH unk", 1'b1, 3'd1, 32'h5002, 32'h0000_ABCD, 1, 0, 32'd0);
    do_access("SW unk mis", 1'b1, 3'd7, 32'h5002, 32'h1, 0, 0, 32'd0);

    // Reset while waiting for read data
    @(negedge clk);
    mem_req = 1'b1; d_wr_en = 1'b0; load_type = 3'd2; addr = 32'h6000;
    @(negedge clk);
    check_eq("rstW in REQ", 32'(bus_req), 32'd1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    check_eq("rstW in WAIT_R", 32'(bus_req), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_eq("rstW bus_req", 32'(bus_req), 32'd0);
    check_eq("rstW done", 32'(done), 32'd0);
    mem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111;
    dcnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus_rvalid = 1'b0;
      if (done) dcnt++;
    end
    check_eq("rstW no done", 32'(dcnt), 32'd0);

    // Reset while the request is on the bus
    mem_req = 1'b1; d_wr_en = 1'b1; store_type = 3'd2; addr = 32'h7000; wdata = 32'h55;
    @(negedge clk);
    check_eq("rstR in REQ", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_eq("rstR bus_req", 32'(bus_req), 32'd0);
    check_eq("rstR bus_addr", bus_addr, 32'd0);
    mem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      bit          we;
      logic [2:0]  ty;
      int          gd, rd;
      we = 1'($urandom);
      ty = 3'($urandom);
      gd = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      rd = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      do_access("rnd", we, ty, $urandom, $urandom, gd, rd, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1);
  end

endmodule
`default_nettype wire
